// File: rtl/unidad_aritmetica_seq_pkg.sv
// Shared definitions for the registered ALU: opcodes, status bit positions and FSM states.
package alu_pkg;

  localparam logic [3:0] OP_SUB  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_NOT  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOTA = 4'd5;
  localparam logic [3:0] OP_NEG  = 4'd6;
  localparam logic [3:0] OP_ASL  = 4'd7;
  localparam logic [3:0] OP_ASR  = 4'd8;
  localparam logic [3:0] OP_LSL  = 4'd9;
  localparam logic [3:0] OP_LSR  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;
  localparam logic [3:0] OP_ADD  = 4'd13;
  localparam logic [3:0] OP_MUL  = 4'd14;
  localparam logic [3:0] OP_RSVD = 4'd15;

  localparam int ST_Z = 4;
  localparam int ST_N = 3;
  localparam int ST_C = 2;
  localparam int ST_V = 1;
  localparam int ST_P = 0;

  // A zero result has Z set and even parity.
  localparam logic [4:0] STATUS_RESET = 5'b10001;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  function automatic logic [4:0] pack_status(input logic z, input logic n, input logic c,
                                             input logic v, input logic p);
    logic [4:0] s;
    s       = '0;
    s[ST_Z] = z;
    s[ST_N] = n;
    s[ST_C] = c;
    s[ST_V] = v;
    s[ST_P] = p;
    return s;
  endfunction

endpackage

// File: rtl/unidad_aritmetica_seq_if.sv
// Start/done request bus of the registered ALU; the datapath side uses the slave modport.
interface unidad_aritmetica_seq_if #(
  parameter int WIDTH = 8
);
  logic             iStart;
  logic [3:0]       iOp;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             oBusy;
  logic             oDone;
  logic [WIDTH-1:0] oR;
  logic [WIDTH-1:0] oRHi;
  logic [4:0]       oStatus;

  modport master (
    output iStart, iOp, iA, iB,
    input  oBusy, oDone, oR, oRHi, oStatus
  );

  modport slave (
    input  iStart, iOp, iA, iB,
    output oBusy, oDone, oR, oRHi, oStatus
  );
endinterface

// File: rtl/unidad_aritmetica_seq_mul.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [2*WIDTH-1:0] step_acc;

  // The step result is exported so the final partial product can be captured on the same edge.
  always_comb begin
    step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (load) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = step_acc;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign last    = busy_q && (cnt_q == CNT_LAST);
  assign product = step_acc;

endmodule

// File: rtl/unidad_aritmetica_seq.sv
// Registered parametrised ALU: single-cycle ops with a one-cycle done pulse, plus an iterative multiply.
module unidad_aritmetica_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                    iClk,
  input logic                    iRst_n,
  unidad_aritmetica_seq_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0]   op_a, op_b;
  logic [SHW-1:0]     sh_n;
  logic [WIDTH:0]     add_w, sub_w, shl_w, shr_w;
  logic [2*WIDTH-1:0] rol_w, ror_w;
  logic [WIDTH-1:0]   asr_r, asl_back;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_c, alu_v;
  logic [4:0]         alu_status, mul_status;

  logic               mul_load, mul_busy, mul_last;
  logic [2*WIDTH-1:0] mul_prod;

  state_e             state_q, state_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [WIDTH-1:0]   rhi_q, rhi_d;
  logic [4:0]         status_q, status_d;

  assign op_a = bus.iA;
  assign op_b = bus.iB;
  assign sh_n = op_b[SHW-1:0];

  // Widened shifts expose the last bit shifted out at the extra position; zero when n is 0.
  always_comb begin
    add_w    = {1'b0, op_a} + {1'b0, op_b};
    sub_w    = {1'b0, op_a} - {1'b0, op_b};
    shl_w    = {1'b0, op_a} << sh_n;
    shr_w    = {op_a, 1'b0} >> sh_n;
    rol_w    = {op_a, op_a} << sh_n;
    ror_w    = {op_a, op_a} >> sh_n;
    asr_r    = $signed(op_a) >>> sh_n;
    asl_back = $signed(shl_w[WIDTH-1:0]) >>> sh_n;
    alu_r    = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (bus.iOp)
      OP_SUB: begin
        alu_r = sub_w[WIDTH-1:0];
        alu_c = sub_w[WIDTH];
        alu_v = (op_a[MSB] != op_b[MSB]) && (alu_r[MSB] != op_a[MSB]);
      end
      OP_AND:  alu_r = op_a & op_b;
      OP_OR:   alu_r = op_a | op_b;
      OP_NOT:  alu_r = ~op_a;
      OP_XOR:  alu_r = op_a ^ op_b;
      OP_NOTA: alu_r = ~op_a;
      OP_NEG:  alu_r = ~op_a + 1'b1;
      OP_ASL: begin
        alu_r = shl_w[WIDTH-1:0];
        alu_c = shl_w[WIDTH];
        alu_v = (asl_back != op_a);
      end
      OP_ASR: begin
        alu_r = asr_r;
        alu_c = shr_w[0];
      end
      OP_LSL: begin
        alu_r = shl_w[WIDTH-1:0];
        alu_c = shl_w[WIDTH];
      end
      OP_LSR: begin
        alu_r = shr_w[WIDTH:1];
        alu_c = shr_w[0];
      end
      OP_ROL: begin
        alu_r = rol_w[2*WIDTH-1:WIDTH];
        alu_c = (sh_n != '0) && alu_r[0];
      end
      OP_ROR: begin
        alu_r = ror_w[WIDTH-1:0];
        alu_c = (sh_n != '0) && alu_r[MSB];
      end
      OP_ADD: begin
        alu_r = add_w[WIDTH-1:0];
        alu_c = add_w[WIDTH];
        alu_v = (op_a[MSB] == op_b[MSB]) && (alu_r[MSB] != op_a[MSB]);
      end
      OP_MUL:  alu_r = '0;
      OP_RSVD: alu_r = '0;
      default: alu_r = '0;
    endcase
    alu_status = pack_status(alu_r == '0, alu_r[MSB], alu_c, alu_v, ~^alu_r);
    mul_status = pack_status(mul_prod == '0, mul_prod[2*WIDTH-1],
                             |mul_prod[2*WIDTH-1:WIDTH], 1'b0, ~^mul_prod);
  end

  assign mul_load = (state_q == S_IDLE) && bus.iStart && (bus.iOp == OP_MUL);

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .load    (mul_load),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .last    (mul_last),
    .product (mul_prod)
  );

  // Requests arriving while a multiply runs are dropped, including on its final cycle.
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    r_d      = r_q;
    rhi_d    = rhi_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (bus.iStart) begin
          if (bus.iOp == OP_MUL) begin
            state_d = S_MUL;
          end else begin
            r_d      = alu_r;
            rhi_d    = '0;
            status_d = alu_status;
            done_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (mul_last) begin
          r_d      = mul_prod[WIDTH-1:0];
          rhi_d    = mul_prod[2*WIDTH-1:WIDTH];
          status_d = mul_status;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      r_q      <= '0;
      rhi_q    <= '0;
      status_q <= STATUS_RESET;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      r_q      <= r_d;
      rhi_q    <= rhi_d;
      status_q <= status_d;
    end
  end

  assign bus.oBusy   = mul_busy;
  assign bus.oDone   = done_q;
  assign bus.oR      = r_q;
  assign bus.oRHi    = rhi_q;
  assign bus.oStatus = status_q;

endmodule

// File: tb/tb_unidad_aritmetica_seq.sv
// Directed bench for unidad_aritmetica_seq at WIDTH=8 with hand-computed results and flags.
module tb_unidad_aritmetica_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails = 0;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [4:0] st;
  } vec_t;

  unidad_aritmetica_seq_if #(.WIDTH(8)) bus_if ();

  unidad_aritmetica_seq #(
    .WIDTH(8)
  ) dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus_if.iStart = 1'b1;
    bus_if.iOp    = op;
    bus_if.iA     = a;
    bus_if.iB     = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [22:0] got, exp;
    bus_if.iStart = 1'b0;
    bus_if.iOp    = 4'd0;
    bus_if.iA     = 8'h00;
    bus_if.iB     = 8'h00;
    rst_n = 1'b0;
    #23;
    got = {bus_if.oBusy, bus_if.oDone, bus_if.oR, bus_if.oRHi, bus_if.oStatus};
    exp = {1'b0, 1'b0, 8'h00, 8'h00, 5'b10001};
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL reset_state: got %h expected %h", got, exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_ops();
    vec_t v[$];
    logic [21:0] got, exp;
    v.push_back('{"sub",       OP_SUB,  8'h05, 8'h07, 8'hFE, 5'b01100});
    v.push_back('{"add_ovf",   OP_ADD,  8'h7F, 8'h01, 8'h80, 5'b01010});
    v.push_back('{"add_carry", OP_ADD,  8'hFF, 8'h01, 8'h00, 5'b10101});
    v.push_back('{"sub_ovf",   OP_SUB,  8'h80, 8'h01, 8'h7F, 5'b00010});
    v.push_back('{"ror",       OP_ROR,  8'h81, 8'h01, 8'hC0, 5'b01101});
    v.push_back('{"asr",       OP_ASR,  8'h80, 8'h03, 8'hF0, 5'b01001});
    v.push_back('{"lsl_n0",    OP_LSL,  8'h81, 8'h00, 8'h81, 5'b01001});
    v.push_back('{"rol_bhigh", OP_ROL,  8'h81, 8'hF9, 8'h03, 5'b00101});
    v.push_back('{"asl_v",     OP_ASL,  8'h40, 8'h01, 8'h80, 5'b01010});
    v.push_back('{"lsr",       OP_LSR,  8'h81, 8'h01, 8'h40, 5'b00100});
    v.push_back('{"neg",       OP_NEG,  8'h01, 8'h00, 8'hFF, 5'b01001});
    v.push_back('{"not",       OP_NOT,  8'h0F, 8'h00, 8'hF0, 5'b01001});
    v.push_back('{"nota",      OP_NOTA, 8'hAA, 8'h00, 8'h55, 5'b00001});
    v.push_back('{"reserved",  OP_RSVD, 8'hFF, 8'hFF, 8'h00, 5'b10001});
    foreach (v[i]) begin
      drive(v[i].op, v[i].a, v[i].b);
      tick();
      bus_if.iStart = 1'b0;
      got = {bus_if.oDone, bus_if.oR, bus_if.oRHi, bus_if.oStatus};
      exp = {1'b1, v[i].r, 8'h00, v[i].st};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL %s: got %h expected %h", v[i].name, got, exp);
      end
    end
  endtask

  task automatic test_mul(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] er, input logic [7:0] erhi, input logic [4:0] est);
    int cycles;
    logic [22:0] got, exp;
    drive(OP_MUL, a, b);
    tick();
    bus_if.iStart = 1'b0;
    checks++;
    if ({bus_if.oBusy, bus_if.oDone} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL %s_accept: got busy/done %b expected 10", name, {bus_if.oBusy, bus_if.oDone});
    end
    cycles = 0;
    while (!bus_if.oDone && cycles < 20) begin
      tick();
      cycles++;
    end
    checks++;
    if (cycles != 8) begin
      fails++;
      $display("[TB] FAIL %s_latency: got %0d cycles expected 8", name, cycles);
    end
    got = {bus_if.oDone, bus_if.oBusy, bus_if.oR, bus_if.oRHi, bus_if.oStatus};
    exp = {1'b1, 1'b0, er, erhi, est};
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s_result: got %h expected %h", name, got, exp);
    end
    tick();
    got = {bus_if.oDone, bus_if.oBusy, bus_if.oR, bus_if.oRHi, bus_if.oStatus};
    exp = {1'b0, 1'b0, er, erhi, est};
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s_hold: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_mul_ignore_start();
    int cycles;
    logic [22:0] got, exp;
    drive(OP_MUL, 8'h03, 8'h05);
    tick();
    drive(OP_ADD, 8'h7F, 8'h01);
    cycles = 0;
    while (!bus_if.oDone && cycles < 20) begin
      tick();
      cycles++;
    end
    bus_if.iStart = 1'b0;
    got = {bus_if.oDone, bus_if.oBusy, bus_if.oR, bus_if.oRHi, bus_if.oStatus};
    exp = {1'b1, 1'b0, 8'h0F, 8'h00, 5'b00001};
    checks++;
    if (got !== exp || cycles != 8) begin
      fails++;
      $display("[TB] FAIL mul_ignore_start: got %h after %0d cycles expected %h after 8", got, cycles, exp);
    end
    tick();
    got = {bus_if.oDone, bus_if.oBusy, bus_if.oR, bus_if.oRHi, bus_if.oStatus};
    exp = {1'b0, 1'b0, 8'h0F, 8'h00, 5'b00001};
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL mul_final_start_dropped: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [22:0] got, exp;
    drive(OP_MUL, 8'hFF, 8'hFF);
    tick();
    bus_if.iStart = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    got = {bus_if.oBusy, bus_if.oDone, bus_if.oR, bus_if.oRHi, bus_if.oStatus};
    exp = {1'b0, 1'b0, 8'h00, 8'h00, 5'b10001};
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL reset_mid_mul: got %h expected %h", got, exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_mul("mul_after_reset", 8'hFF, 8'hFF, 8'h01, 8'hFE, 5'b01101);
  endtask

  task automatic test_back_to_back();
    logic [21:0] got, exp;
    logic [3:0]  ops [3];
    logic [7:0]  res [3];
    logic [4:0]  sts [3];
    ops = '{OP_AND, OP_OR, OP_XOR};
    res = '{8'h30, 8'hFC, 8'hCC};
    sts = '{5'b00001, 5'b01001, 5'b01001};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], 8'hF0, 8'h3C);
      tick();
      got = {bus_if.oDone, bus_if.oR, bus_if.oRHi, bus_if.oStatus};
      exp = {1'b1, res[i], 8'h00, sts[i]};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("[TB] FAIL b2b_%0d: got %h expected %h", i, got, exp);
      end
    end
    bus_if.iStart = 1'b0;
    tick();
    got = {bus_if.oDone, bus_if.oR, bus_if.oRHi, bus_if.oStatus};
    exp = {1'b0, 8'hCC, 8'h00, 5'b01001};
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL b2b_idle_hold: got %h expected %h", got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting unidad_aritmetica_seq bench");
    test_reset();
    test_single_ops();
    test_mul("mul_0f_11", 8'h0F, 8'h11, 8'hFF, 8'h00, 5'b00001);
    test_mul("mul_ff_ff", 8'hFF, 8'hFF, 8'h01, 8'hFE, 5'b01101);
    test_mul_ignore_start();
    test_reset_mid_mul();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
